// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the mem_stall_responder slice: FSM state
// encoding, tag/index width derivation, byte-lane merge and saturating add.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    D_MISS,
    I_MISS
  } state_t;

  function automatic int unsigned tag_width(input int unsigned lines_log2,
                                            input int unsigned line_words_log2);
    return 30 - lines_log2 - line_words_log2;
  endfunction

  function automatic int unsigned idx_width(input int unsigned lines_log2);
    return (lines_log2 > 0) ? lines_log2 : 1;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a,
                                            input logic [1:0]  inc);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/mem_resp_tag_array.sv
// Direct-mapped tag model for one cache port: valid+tag per line,
// combinational lookup on the request word address, fill at end of service.
module mem_resp_tag_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned LINES_LOG2      = 4,
  parameter int unsigned LINE_WORDS_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_word,
  output logic        hit,
  input  logic        fill_en,
  input  logic [29:0] fill_word
);

  localparam int unsigned TAG_W = tag_width(LINES_LOG2, LINE_WORDS_LOG2);
  localparam int unsigned IDX_W = idx_width(LINES_LOG2);
  localparam int unsigned LINES = 1 << LINES_LOG2;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  logic [IDX_W-1:0] l_idx;
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] l_tag;
  logic [TAG_W-1:0] f_tag;
  logic             unused_word_bits;

  assign l_idx = lookup_word[LINE_WORDS_LOG2 +: IDX_W];
  assign f_idx = fill_word[LINE_WORDS_LOG2 +: IDX_W];
  assign l_tag = lookup_word[29 -: TAG_W];
  assign f_tag = fill_word[29 -: TAG_W];
  assign unused_word_bits = ^{lookup_word[LINE_WORDS_LOG2-1:0], fill_word[LINE_WORDS_LOG2-1:0]};

  assign hit = valid[l_idx] && (tags[l_idx] == l_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[f_idx] <= 1'b1;
      tags[f_idx]  <= f_tag;
    end
  end

endmodule

// File: rtl/mem_stall_responder.sv
// Riscv150 icache/dcache responder: dual-port word RAM with per-port tag
// models and fixed-latency miss stalls. Define MEM_RESP_STATS_EN for hit/miss counters.
module mem_stall_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2      = 12,
  parameter int unsigned LINES_LOG2      = 4,
  parameter int unsigned LINE_WORDS_LOG2 = 2,
  parameter int unsigned MISS_LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] icache_addr,
  input  logic        icache_re,
  input  logic [3:0]  icache_we,
  input  logic [31:0] icache_din,
  output logic [31:0] icache_dout,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_LATENCY - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic i_req, d_req, i_hit_raw, d_hit_raw;
  logic i_hit, d_hit, i_miss, d_miss, any_miss;
  logic accept, cnt_zero, d_fill, i_fill, done;
  logic unused_addr_bits;

  logic [29:0] p_i_word, p_d_word;
  logic [31:0] p_i_din, p_d_din;
  logic [3:0]  p_i_we, p_d_we;
  logic        p_i_re, p_d_re, p_i_miss;

  logic                  i_wr_en, d_wr_en, i_rd_en, d_rd_en;
  logic [3:0]            i_wr_we, d_wr_we;
  logic [31:0]           i_wr_din, d_wr_din, d_base;
  logic [DEPTH_LOG2-1:0] i_wa, d_wa;

  logic [31:0] mem [1 << DEPTH_LOG2];

  assign unused_addr_bits = ^{icache_addr[1:0], dcache_addr[1:0]};

  assign i_req    = icache_re | (|icache_we);
  assign d_req    = dcache_re | (|dcache_we);
  assign i_hit    = i_req & i_hit_raw;
  assign d_hit    = d_req & d_hit_raw;
  assign i_miss   = i_req & ~i_hit_raw;
  assign d_miss   = d_req & ~d_hit_raw;
  assign any_miss = i_miss | d_miss;

  assign accept   = (state == IDLE);
  assign stall    = (state != IDLE);
  assign cnt_zero = (cnt == '0);
  assign d_fill   = (state == D_MISS) && cnt_zero;
  assign i_fill   = (state == I_MISS) && cnt_zero;
  assign done     = (d_fill && !p_i_miss) || i_fill;

  mem_resp_tag_array #(
    .LINES_LOG2      (LINES_LOG2),
    .LINE_WORDS_LOG2 (LINE_WORDS_LOG2)
  ) u_itags (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (icache_addr[31:2]),
    .hit         (i_hit_raw),
    .fill_en     (i_fill),
    .fill_word   (p_i_word)
  );

  mem_resp_tag_array #(
    .LINES_LOG2      (LINES_LOG2),
    .LINE_WORDS_LOG2 (LINE_WORDS_LOG2)
  ) u_dtags (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (dcache_addr[31:2]),
    .hit         (d_hit_raw),
    .fill_en     (d_fill),
    .fill_word   (p_d_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (any_miss) begin
          state_n = d_miss ? D_MISS : I_MISS;
          cnt_n   = CNT_LOAD;
        end
      end
      D_MISS: begin
        if (cnt_zero) begin
          if (p_i_miss) begin
            state_n = I_MISS;
            cnt_n   = CNT_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      I_MISS: begin
        if (cnt_zero) state_n = IDLE;
        else          cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Only a missing port's write is deferred; a hit port commits at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_i_we   <= '0;
      p_d_we   <= '0;
      p_i_re   <= 1'b0;
      p_d_re   <= 1'b0;
      p_i_miss <= 1'b0;
    end else if (accept && any_miss) begin
      p_i_word <= icache_addr[31:2];
      p_d_word <= dcache_addr[31:2];
      p_i_din  <= icache_din;
      p_d_din  <= dcache_din;
      p_i_we   <= i_miss ? icache_we : 4'b0000;
      p_d_we   <= d_miss ? dcache_we : 4'b0000;
      p_i_re   <= icache_re;
      p_d_re   <= dcache_re;
      p_i_miss <= i_miss;
    end
  end

  always_comb begin
    i_wr_en  = 1'b0;
    d_wr_en  = 1'b0;
    i_rd_en  = 1'b0;
    d_rd_en  = 1'b0;
    i_wr_we  = icache_we;
    d_wr_we  = dcache_we;
    i_wr_din = icache_din;
    d_wr_din = dcache_din;
    i_wa     = icache_addr[DEPTH_LOG2+1:2];
    d_wa     = dcache_addr[DEPTH_LOG2+1:2];
    if (accept) begin
      i_wr_en = i_hit && (|icache_we);
      d_wr_en = d_hit && (|dcache_we);
      i_rd_en = !any_miss && icache_re;
      d_rd_en = !any_miss && dcache_re;
    end else if (done) begin
      i_wr_en  = |p_i_we;
      d_wr_en  = |p_d_we;
      i_rd_en  = p_i_re;
      d_rd_en  = p_d_re;
      i_wr_we  = p_i_we;
      d_wr_we  = p_d_we;
      i_wr_din = p_i_din;
      d_wr_din = p_d_din;
      i_wa     = p_i_word[DEPTH_LOG2-1:0];
      d_wa     = p_d_word[DEPTH_LOG2-1:0];
    end
  end

  // dcache merges on top of the icache result so its enabled bytes win on a shared word.
  assign d_base = (i_wr_en && (i_wa == d_wa)) ? byte_merge(mem[d_wa], i_wr_din, i_wr_we)
                                              : mem[d_wa];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (i_wr_en) mem[i_wa] <= byte_merge(mem[i_wa], i_wr_din, i_wr_we);
      if (d_wr_en) mem[d_wa] <= byte_merge(d_base, d_wr_din, d_wr_we);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icache_dout <= '0;
      dcache_dout <= '0;
    end else begin
      if (i_rd_en) icache_dout <= mem[i_wa];
      if (d_rd_en) dcache_dout <= mem[d_wa];
    end
  end

`ifdef MEM_RESP_STATS_EN
  logic [1:0] hits_now, misses_now;

  assign hits_now   = {1'b0, accept & i_hit}  + {1'b0, accept & d_hit};
  assign misses_now = {1'b0, accept & i_miss} + {1'b0, accept & d_miss};

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= sat_add32(hit_count, hits_now);
      miss_count <= sat_add32(miss_count, misses_now);
    end
  end
`endif

endmodule
